unidade_de_busca: RTL

UNIDADE_DE_BUSCA -- requirements
Module: unidade_de_busca

---
 rtl/unidade_de_busca_pkg.sv | 21 ++
 rtl/unidade_de_busca_proximo_pc.sv | 37 +++
 rtl/unidade_de_busca.sv | 106 ++++++++++
 3 files changed

// File: rtl/unidade_de_busca_pkg.sv
// rtl/unidade_de_busca_pkg.sv - shared types and constants for the instruction fetch unit
//
// Contents:
//   busca_state_t    two-state fetch/execute sequencer encoding
//   PC_SEQ..PC_JUMP  codes carried on pcSource
//   DEFAULT_RESET_PC PC loaded on reset unless overridden
package unidade_de_busca_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } busca_state_t;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_REG    = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/unidade_de_busca_proximo_pc.sv
// rtl/unidade_de_busca_proximo_pc.sv - combinational next-PC mux and increment
//
// Ports:
//   pc        in   current PC
//   pc_source in   next-PC select (PC_SEQ / PC_BRANCH / PC_REG / PC_JUMP)
//   jump_addr in   26-bit immediate target
//   reg_addr  in   register-file value for jr
//   pc_plus1  out  pc+1, wraps silently
//   next_pc   out  selected next PC
module unidade_de_busca_proximo_pc
    import unidade_de_busca_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [PC_W-1:0] pc,
    input  logic [1:0]      pc_source,
    input  logic [25:0]     jump_addr,
    input  logic [PC_W-1:0] reg_addr,
    output logic [PC_W-1:0] pc_plus1,
    output logic [PC_W-1:0] next_pc
);

    assign pc_plus1 = pc + PC_W'(1);

    // Jump targets keep the upper bits of the incremented PC, so a jump
    // from the last word of a 2^26 region lands in the following region.
    always_comb begin
        next_pc = pc_plus1;
        case (pc_source)
            PC_SEQ:            next_pc = pc_plus1;
            PC_BRANCH, PC_JUMP: next_pc = {pc_plus1[PC_W-1:26], jump_addr};
            PC_REG:            next_pc = reg_addr;
            default:           next_pc = pc_plus1;
        endcase
    end

endmodule

// File: rtl/unidade_de_busca.sv
// rtl/unidade_de_busca.sv - two-state instruction fetch unit with hold and next-PC selection
//
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   interrupt        hold request, only honoured in EXEC
//   pcSource         next-PC select
//   jumpAddr         immediate target field
//   regAddr          jr target
//   imemReq/imemAddr instruction-memory request and word address
//   imemValid/Data   instruction-memory response
//   instr            instruction register
//   instrValid       instr holds the instruction under execution
//   instrCommit      one-cycle retire pulse
//   pc, pcPlus1      address of instr and its successor
module unidade_de_busca
    import unidade_de_busca_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            interrupt,
    input  logic [1:0]      pcSource,
    input  logic [25:0]     jumpAddr,
    input  logic [PC_W-1:0] regAddr,
    output logic            imemReq,
    output logic [PC_W-1:0] imemAddr,
    input  logic            imemValid,
    input  logic [31:0]     imemData,
    output logic [31:0]     instr,
    output logic            instrValid,
    output logic            instrCommit,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pcPlus1
);

    busca_state_t    state_q;
    busca_state_t    state_d;
    logic [PC_W-1:0] pc_q;
    logic [31:0]     instr_q;
    logic [PC_W-1:0] next_pc;
    logic            load_instr;
    logic            load_pc;

    unidade_de_busca_proximo_pc #(
        .PC_W (PC_W)
    ) u_proximo_pc (
        .pc        (pc_q),
        .pc_source (pcSource),
        .jump_addr (jumpAddr),
        .reg_addr  (regAddr),
        .pc_plus1  (pcPlus1),
        .next_pc   (next_pc)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_pc) begin
                pc_q <= next_pc;
            end
            if (load_instr) begin
                instr_q <= imemData;
            end
        end
    end

    // A response arriving outside FETCH is dropped because load_instr is
    // only raised in FETCH; the commit pulse is what moves the PC.
    always_comb begin
        state_d     = state_q;
        load_instr  = 1'b0;
        load_pc     = 1'b0;
        imemReq     = 1'b0;
        instrValid  = 1'b0;
        instrCommit = 1'b0;
        case (state_q)
            FETCH: begin
                imemReq = 1'b1;
                if (imemValid) begin
                    load_instr = 1'b1;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                instrValid = 1'b1;
                if (!interrupt) begin
                    instrCommit = 1'b1;
                    load_pc     = 1'b1;
                    state_d     = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    assign imemAddr = pc_q;
    assign pc       = pc_q;
    assign instr    = instr_q;

endmodule
